// File: rtl/prefix_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Sklansky adder.
// The cell map decides, per (level, bit), whether a prefix cell exists and its kind.
package prefix_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_ADC = 2'd1,
    OP_SUB = 2'd2,
    OP_SBB = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    CELL_NONE,
    CELL_GREY,
    CELL_BLACK
  } cell_e;

  function automatic int levels_f(input int width);
    return $clog2(width);
  endfunction

  function automatic int lat_f(input int width, input int pipe_every);
    return (levels_f(width) + pipe_every - 1) / pipe_every + 1;
  endfunction

  // A group whose span reaches bit 0 already holds the carry-in, so only G matters.
  function automatic cell_e cell_kind(input int level, input int bit_idx);
    int span_lo;
    if (((bit_idx >> level) & 1) == 0) return CELL_NONE;
    span_lo = bit_idx & ~((2 << level) - 1);
    return (span_lo == 0) ? CELL_GREY : CELL_BLACK;
  endfunction

  function automatic int partner(input int level, input int bit_idx);
    return (bit_idx & ~((2 << level) - 1)) + (1 << level) - 1;
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// One prefix operator node: merges a high group (gh/ph) with the adjacent low group.
// Grey cells drop the group-propagate because nothing downstream consumes it.
module prefix_cell #(
  parameter bit BLACK = 1'b1
) (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);

  if (BLACK) begin : g_black
    assign p = ph & pl;
  end else begin : g_grey
    logic unused_pl;
    assign unused_pl = pl;
    assign p         = 1'b0;
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky adder/subtractor with carry/borrow-in, status flags and valid/ready.
// A single global stall freezes every stage, so beats keep their relative positions.
module prefix_adder_pipe
  import prefix_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PIPE_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = levels_f(WIDTH);
  localparam int NSTAGE = lat_f(WIDTH, PIPE_EVERY) - 1;

  logic             stall;
  logic [WIDTH-1:0] b_eff_d;
  logic             c0_d;

  logic [WIDTH-1:0] x_q  [NSTAGE];
  logic [WIDTH-1:0] g_q  [NSTAGE];
  logic [WIDTH-1:0] p_q  [NSTAGE];
  logic             c0_q [NSTAGE];
  logic             v_q  [NSTAGE];

  logic [WIDTH-1:0] lin_g  [LEVELS];
  logic [WIDTH-1:0] lin_p  [LEVELS];
  logic [WIDTH-1:0] lout_g [LEVELS];
  logic [WIDTH-1:0] lout_p [LEVELS];

  logic [WIDTH-1:0] carry_d;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, ovf_d, zero_d;
  logic             cout_q, ovf_q, zero_q, out_valid_q;
  logic             unused_p;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    b_eff_d = b;
    c0_d    = 1'b0;
    case (op_t'(op))
      OP_ADC:  c0_d = cin;
      OP_SUB:  begin b_eff_d = ~b; c0_d = 1'b1; end
      OP_SBB:  begin b_eff_d = ~b; c0_d = ~cin; end
      default: ;
    endcase
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    if (k % PIPE_EVERY != 0) begin : g_chain
      assign lin_g[k] = lout_g[k-1];
      assign lin_p[k] = lout_p[k-1];
    end else if (k == 0) begin : g_first
      // Carry-in is folded into bit 0, making every group reaching bit 0 a G_{i:-1}.
      assign lin_g[0] = {g_q[0][WIDTH-1:1], g_q[0][0] | (p_q[0][0] & c0_q[0])};
      assign lin_p[0] = p_q[0];
    end else begin : g_reg
      assign lin_g[k] = g_q[k/PIPE_EVERY];
      assign lin_p[k] = p_q[k/PIPE_EVERY];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (cell_kind(k, i) == CELL_NONE) begin : g_pass
        assign lout_g[k][i] = lin_g[k][i];
        assign lout_p[k][i] = lin_p[k][i];
      end else begin : g_cell
        prefix_cell #(.BLACK(cell_kind(k, i) == CELL_BLACK)) u_cell (
          .gh (lin_g[k][i]),
          .ph (lin_p[k][i]),
          .gl (lin_g[k][partner(k, i)]),
          .pl (lin_p[k][partner(k, i)]),
          .g  (lout_g[k][i]),
          .p  (lout_p[k][i])
        );
      end
    end
  end

  always_comb begin
    carry_d = {lout_g[LEVELS-1][WIDTH-2:0], c0_q[NSTAGE-1]};
    sum_d   = x_q[NSTAGE-1] ^ carry_d;
    cout_d  = lout_g[LEVELS-1][WIDTH-1];
    ovf_d   = carry_d[WIDTH-1] ^ cout_d;
    zero_d  = ~|sum_d;
  end

  assign unused_p = ^lout_p[LEVELS-1];

  // NOTE: in-flight data registers are not reset; their valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (in_valid) begin
        x_q[0]  <= a ^ b_eff_d;
        g_q[0]  <= a & b_eff_d;
        p_q[0]  <= a | b_eff_d;
        c0_q[0] <= c0_d;
      end
      for (int j = 1; j < NSTAGE; j++) begin
        if (v_q[j-1]) begin
          x_q[j]  <= x_q[j-1];
          g_q[j]  <= lout_g[j*PIPE_EVERY-1];
          p_q[j]  <= lout_p[j*PIPE_EVERY-1];
          c0_q[j] <= c0_q[j-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NSTAGE; j++) v_q[j] <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      for (int j = 1; j < NSTAGE; j++) v_q[j] <= v_q[j-1];
      out_valid_q <= v_q[NSTAGE-1];
      if (v_q[NSTAGE-1]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe: directed corners, stream, backpressure, reset,
// plus a latency/result sweep over several WIDTH x PIPE_EVERY configurations.
module tb_prefix_adder_pipe;
  import prefix_pkg::*;

  localparam int W        = 16;
  localparam int LAT_MAIN = 3;
  localparam int NSW      = 11;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  function automatic int sw_w(input int i);
    case (i)
      0, 1:    return 4;
      2, 3, 4: return 16;
      5, 6, 7: return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int sw_p(input int i);
    case (i)
      0: return 1;  1: return 2;  2: return 1;  3: return 2;  4: return 4;
      5: return 1;  6: return 2;  7: return 5;  8: return 1;  9: return 2;
      default: return 6;
    endcase
  endfunction

  function automatic int sw_lat(input int i);
    case (i)
      0: return 3;  1: return 2;  2: return 5;  3: return 3;  4: return 2;
      5: return 6;  6: return 4;  7: return 2;  8: return 7;  9: return 4;
      default: return 2;
    endcase
  endfunction

  // Reference: plain wide addition of a, the effective b and the effective carry-in.
  function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic mcin, input logic [1:0] mop, input int w);
    exp_t        r;
    logic [64:0] mask, full;
    logic [63:0] be, aa;
    logic        c0;
    mask = (65'd1 << w) - 65'd1;
    aa   = ma & mask[63:0];
    be   = (mop[1] ? ~mb : mb) & mask[63:0];
    case (mop)
      2'd0:    c0 = 1'b0;
      2'd1:    c0 = mcin;
      2'd2:    c0 = 1'b1;
      default: c0 = ~mcin;
    endcase
    full   = {1'b0, aa} + {1'b0, be} + {64'd0, c0};
    r.sum  = full[63:0] & mask[63:0];
    r.cout = full[w];
    r.ovf  = (aa[w-1] == be[w-1]) && (r.sum[w-1] != aa[w-1]);
    r.zero = (r.sum == 64'd0);
    r.acc  = 0;
    return r;
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0]  a, b, sum;
  logic [1:0]    op;

  logic          sw_valid, sw_cin;
  logic [1:0]    sw_op;
  logic [63:0]   sw_a, sw_b;
  logic          sw_rdy [NSW];
  logic          sw_ov  [NSW];
  logic          sw_co  [NSW];
  logic          sw_of  [NSW];
  logic          sw_z   [NSW];
  logic [63:0]   sw_sum [NSW];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fire   = 0;
  int   cyc      = 0;
  logic chk_lat  = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  prefix_adder_pipe #(.WIDTH(W), .PIPE_EVERY(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  for (genvar g = 0; g < NSW; g++) begin : g_sw
    localparam int SW = sw_w(g);
    logic [SW-1:0] s;
    prefix_adder_pipe #(.WIDTH(SW), .PIPE_EVERY(sw_p(g))) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid),
      .in_ready  (sw_rdy[g]),
      .a         (sw_a[SW-1:0]),
      .b         (sw_b[SW-1:0]),
      .cin       (sw_cin),
      .op        (sw_op),
      .out_valid (sw_ov[g]),
      .out_ready (1'b1),
      .sum       (s),
      .cout      (sw_co[g]),
      .ovf       (sw_of[g]),
      .zero      (sw_z[g])
    );
    assign sw_sum[g] = 64'(s);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Samples both handshakes just after the drive point, then advances one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst) begin
      if (in_valid && in_ready) begin
        e     = model(64'(a), 64'(b), cin, op, W);
        e.acc = cyc;
        sb_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        n_fire++;
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("sum", 64'(sum), e.sum);
          check("cout", 64'(cout), 64'(e.cout));
          check("ovf", 64'(ovf), 64'(e.ovf));
          check("zero", 64'(zero), 64'(e.zero));
          if (chk_lat) check("latency", 64'(cyc - e.acc), 64'(LAT_MAIN));
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [1:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb,
                      input logic scin);
    op = sop; a = sa; b = sb; cin = scin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drive_rand();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    op  = 2'($urandom);
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    exp_t         e;
    logic         got [NSW];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = OP_ADD;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_op = OP_ADD;
    held = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    chk_lat = 1'b1;
    send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    drain(20);
    send(OP_SUB, 16'h8000, 16'h0001, 1'b0);
    send(OP_SBB, 16'h0000, 16'h0000, 1'b1);
    send(OP_ADC, 16'h7FFF, 16'h0000, 1'b1);
    send(OP_ADD, 16'h0000, 16'h0000, 1'b1);
    drain(20);

    n_fire = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      tick();
    end
    check("stream_rate", 64'(n_fire), 64'd97);
    drain(20);

    chk_lat = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      tick();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      drive_rand();
      #1;
      if (s == 0) held = sum;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      if (s != 0) check("bp_hold", 64'(sum), 64'(held));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      tick();
    end
    drain(20);

    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk_lat = 1'b1;
    send(OP_SUB, 16'h1234, 16'h1234, 1'b0);
    drain(20);

    for (int v = 0; v < 6; v++) begin
      sw_a   = {$urandom, $urandom};
      sw_b   = {$urandom, $urandom};
      sw_cin = 1'($urandom);
      sw_op  = 2'(v);
      if (v == 0) begin sw_a = '1; sw_b = 64'd1; end
      if (v == 2) begin sw_a = '0; sw_b = 64'd1; end
      for (int i = 0; i < NSW; i++) begin
        got[i] = 1'b0;
        check($sformatf("sw%0d_in_ready", i), 64'(sw_rdy[i]), 64'd1);
      end
      sw_valid = 1'b1;
      @(negedge clk);
      sw_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        for (int i = 0; i < NSW; i++) begin
          if (!got[i] && sw_ov[i]) begin
            got[i] = 1'b1;
            e = model(sw_a, sw_b, sw_cin, sw_op, sw_w(i));
            check($sformatf("sw%0d_lat", i), 64'(c), 64'(sw_lat(i)));
            check($sformatf("sw%0d_sum", i), sw_sum[i], e.sum);
            check($sformatf("sw%0d_flags", i), {61'd0, sw_co[i], sw_of[i], sw_z[i]},
                  {61'd0, e.cout, e.ovf, e.zero});
          end
        end
        @(negedge clk);
      end
      for (int i = 0; i < NSW; i++) check($sformatf("sw%0d_seen", i), 64'(got[i]), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
